// File: rtl/result_byte_streamer.sv
// -----------------------------------------------------------------------------
// result_byte_streamer
//
// Buffers 32-bit write-back results from the processor core in a small FIFO
// and streams them out one byte per cycle, little-endian (byte 0 first), over
// a valid/ready byte interface. Dropped captures (FIFO full) raise a sticky
// overflow flag that only reset clears.
//
// Ports
//   clk           in   rising-edge clock shared with the core
//   reset         in   synchronous, active-high reset
//   Result_i      in   [31:0] result word from the core
//   Capture_i     in   push request for Result_i this cycle
//   Byte_Ready_i  in   sink accepts Byte_o this cycle
//   Byte_o        out  [7:0] current outgoing byte (8'h00 when idle)
//   Byte_Valid_o  out  Byte_o holds a valid byte
//   Fifo_Count_o  out  [CNT_W-1:0] words buffered, excluding the serializer word
//   Full_o        out  Fifo_Count_o == FIFO_DEPTH
//   Empty_o       out  Fifo_Count_o == 0
//   Overflow_o    out  sticky: a capture was dropped
// -----------------------------------------------------------------------------
module result_byte_streamer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Result_i,
    input  logic             Capture_i,
    input  logic             Byte_Ready_i,
    output logic [7:0]       Byte_o,
    output logic             Byte_Valid_o,
    output logic [CNT_W-1:0] Fifo_Count_o,
    output logic             Full_o,
    output logic             Empty_o,
    output logic             Overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [31:0]      mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic [0:0]       state_q,  state_d;
    logic [1:0]       idx_q,    idx_d;
    logic [31:0]      hold_q,   hold_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic last_byte_taken;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = Capture_i && !full;

    // Final byte of the held word is being accepted this cycle.
    assign last_byte_taken = (state_q == ST_SEND) && Byte_Ready_i && (idx_q == 2'd3);

    // Pop either to start from idle or to chain the next word without a bubble.
    assign pop = !empty && ((state_q == ST_IDLE) || last_byte_taken);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Full is evaluated before any same-edge pop, so the drop is sticky
        // even when a pop frees a slot at that edge.
        if (Capture_i && full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    hold_d  = mem_q[rd_ptr_q];
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (Byte_Ready_i) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (pop) begin
                        hold_d = mem_q[rd_ptr_q];
                        idx_d  = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= Result_i;
        end
    end

    always_comb begin
        Byte_o = 8'h00;
        if (state_q == ST_SEND) begin
            case (idx_q)
                2'd0:    Byte_o = hold_q[7:0];
                2'd1:    Byte_o = hold_q[15:8];
                2'd2:    Byte_o = hold_q[23:16];
                default: Byte_o = hold_q[31:24];
            endcase
        end
    end

    assign Byte_Valid_o = (state_q == ST_SEND);
    assign Fifo_Count_o = count_q;
    assign Full_o       = full;
    assign Empty_o      = empty;
    assign Overflow_o   = ovf_q;

endmodule
